// File: rtl/calc_entry_seq.sv
// calc_entry_seq
//   Operator-entry front end of the 4-bit calculator. It synchronizes the raw
//   value/op switches and the two pushbuttons, debounces the buttons, and
//   walks the user through operand A -> operation -> operand B. It then holds
//   a stable, valid operand set for the ALU.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   sw         in   4  raw value switches (operand A/B)
//   op_sel     in   2  raw op switches: 00 Sub, 01 Add, 10 Or, 11 twoscomp (unary)
//   btn_enter  in   1  raw enter pushbutton, active-high, bouncy
//   btn_clear  in   1  raw clear pushbutton, active-high, bouncy
//   i1         out  4  operand A, registered
//   i2         out  4  operand B, registered
//   ctrl       out  2  operation code, registered
//   valid      out  1  high while a complete operand set is held (DONE)
//   stage      out  2  entry state: 0 S_A, 1 S_OP, 2 S_B, 3 DONE
//
// Handshake: there is none toward the ALU. i1/i2/ctrl change only on the edge
// that consumes an enter/clear pulse. valid marks the cycles in which the set
// is complete.
module calc_entry_seq #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic [1:0] op_sel,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] i1,
  output logic [3:0] i2,
  output logic [1:0] ctrl,
  output logic       valid,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_OP   = 2'd1,
    S_B    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // Two-flop synchronizers
  logic [3:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [1:0] op_s1_q, op_s1_d, op_s2_q, op_s2_d;
  logic       ent_s1_q, ent_s1_d, ent_s2_q, ent_s2_d;
  logic       clr_s1_q, clr_s1_d, clr_s2_q, clr_s2_d;

  // Debounce counters and accepted levels
  logic [DB_W-1:0] ent_cnt_q, ent_cnt_d, clr_cnt_q, clr_cnt_d;
  logic            ent_db_q, ent_db_d, clr_db_q, clr_db_d;

  // Entry FSM and operand registers
  state_t     state_q, state_d;
  logic [3:0] i1_q, i1_d, i2_q, i2_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic       valid_q, valid_d;

  logic enter_p, clear_p;

  // A pulse fires in the cycle the debounced level flips 0->1. This is the
  // last mismatched cycle of a pending press. Because the debounced levels
  // reset to 0 alongside the synchronizers, reset release cannot create one.
  assign enter_p = ent_s2_q & ~ent_db_q & (ent_cnt_q == DB_LAST);
  assign clear_p = clr_s2_q & ~clr_db_q & (clr_cnt_q == DB_LAST);

  always_comb begin
    sw_s1_d  = sw;
    sw_s2_d  = sw_s1_q;
    op_s1_d  = op_sel;
    op_s2_d  = op_s1_q;
    ent_s1_d = btn_enter;
    ent_s2_d = ent_s1_q;
    clr_s1_d = btn_clear;
    clr_s2_d = clr_s1_q;

    ent_cnt_d = '0;
    ent_db_d  = ent_db_q;
    clr_cnt_d = '0;
    clr_db_d  = clr_db_q;

    state_d = state_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;

    // Any agreeing cycle restarts the count, so short glitches never flip.
    if (ent_s2_q != ent_db_q) begin
      if (ent_cnt_q == DB_LAST) begin
        ent_db_d = ~ent_db_q;
      end else begin
        ent_cnt_d = ent_cnt_q + DB_ONE;
      end
    end
    if (clr_s2_q != clr_db_q) begin
      if (clr_cnt_q == DB_LAST) begin
        clr_db_d = ~clr_db_q;
      end else begin
        clr_cnt_d = clr_cnt_q + DB_ONE;
      end
    end

    if (clear_p) begin
      i1_d    = 4'd0;
      i2_d    = 4'd0;
      ctrl_d  = 2'b00;
      valid_d = 1'b0;
      state_d = S_A;
    end else if (enter_p && !clr_db_q) begin
      // A held clear suppresses entry until clear is released.
      case (state_q)
        S_A: begin
          i1_d    = sw_s2_q;
          i2_d    = 4'd0;
          state_d = S_OP;
        end
        S_OP: begin
          ctrl_d = op_s2_q;
          if (op_s2_q == 2'b11) begin
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_B;
          end
        end
        S_B: begin
          i2_d    = sw_s2_q;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          i1_d    = sw_s2_q;
          i2_d    = 4'd0;
          valid_d = 1'b0;
          state_d = S_OP;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      op_s1_q   <= '0;
      op_s2_q   <= '0;
      ent_s1_q  <= 1'b0;
      ent_s2_q  <= 1'b0;
      clr_s1_q  <= 1'b0;
      clr_s2_q  <= 1'b0;
      ent_cnt_q <= '0;
      clr_cnt_q <= '0;
      ent_db_q  <= 1'b0;
      clr_db_q  <= 1'b0;
      state_q   <= S_A;
      i1_q      <= 4'd0;
      i2_q      <= 4'd0;
      ctrl_q    <= 2'b00;
      valid_q   <= 1'b0;
    end else begin
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      op_s1_q   <= op_s1_d;
      op_s2_q   <= op_s2_d;
      ent_s1_q  <= ent_s1_d;
      ent_s2_q  <= ent_s2_d;
      clr_s1_q  <= clr_s1_d;
      clr_s2_q  <= clr_s2_d;
      ent_cnt_q <= ent_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      ent_db_q  <= ent_db_d;
      clr_db_q  <= clr_db_d;
      state_q   <= state_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
    end
  end

  assign i1    = i1_q;
  assign i2    = i2_q;
  assign ctrl  = ctrl_q;
  assign valid = valid_q;
  assign stage = state_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Bench for calc_entry_seq with DEBOUNCE_CYCLES=4. It drives directed button
// and switch sequences. A reference model of the entry sequence pushes the
// expected {i1,i2,ctrl,valid,stage} word per step. The DUT word is popped
// and compared once the step has settled.
module tb_calc_entry_seq;

  localparam int N = 4;

  // clock / reset
  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [1:0] op_sel;
  logic       btn_enter;
  logic       btn_clear;
  logic [3:0] i1;
  logic [3:0] i2;
  logic [1:0] ctrl;
  logic       valid;
  logic [1:0] stage;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  calc_entry_seq #(.DEBOUNCE_CYCLES(N), .DB_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .op_sel    (op_sel),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .i1        (i1),
    .i2        (i2),
    .ctrl      (ctrl),
    .valid     (valid),
    .stage     (stage)
  );

  // scoreboard
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;

  // reference model
  logic [3:0] m_i1;
  logic [3:0] m_i2;
  logic [1:0] m_ctrl;
  logic [1:0] m_stage;

  // S_B watch for the unary-op path
  logic watch_sb = 1'b0;
  logic seen_sb  = 1'b0;
  always @(negedge clk) if (watch_sb && stage == 2'd2) seen_sb <= 1'b1;

  function automatic logic [12:0] model_word();
    return {m_i1, m_i2, m_ctrl, (m_stage == 2'd3), m_stage};
  endfunction

  task automatic model_clear();
    m_i1 = 4'd0; m_i2 = 4'd0; m_ctrl = 2'd0; m_stage = 2'd0;
  endtask

  task automatic model_enter(input logic [3:0] s, input logic [1:0] o);
    case (m_stage)
      2'd0: begin m_i1 = s; m_i2 = 4'd0; m_stage = 2'd1; end
      2'd1: begin m_ctrl = o; m_stage = (o == 2'b11) ? 2'd3 : 2'd2; end
      2'd2: begin m_i2 = s; m_stage = 2'd3; end
      default: begin m_i1 = s; m_i2 = 4'd0; m_stage = 2'd1; end
    endcase
  endtask

  task automatic push_exp();
    exp_q.push_back(model_word());
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_out(input string tag);
    logic [12:0] obs;
    logic [12:0] expv;
    obs = {i1, i2, ctrl, valid, stage};
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s no expected entry queued, observed=%h", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic press(input logic ent, input logic clr, input int hold);
    btn_enter = ent;
    btn_clear = clr;
    tick(hold);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(N + 6);
  endtask

  task automatic enter_step(input logic [3:0] s, input logic [1:0] o, input int hold);
    sw     = s;
    op_sel = o;
    tick(3);
    model_enter(s, o);
    push_exp();
    press(1'b1, 1'b0, hold);
  endtask

  task automatic clear_step();
    model_clear();
    push_exp();
    press(1'b0, 1'b1, N + 6);
  endtask

  initial begin
    rst = 1'b1; sw = 4'd0; op_sel = 2'd0; btn_enter = 1'b0; btn_clear = 1'b0;
    model_clear();
    tick(3);
    push_exp();
    check_out("reset_state");
    rst = 1'b0;
    tick(12);
    push_exp();
    check_out("rst_release_no_pulse");

    // full two-operand entry
    enter_step(4'd5, 2'b00, N + 6); check_out("t2_capture_a");
    enter_step(4'd0, 2'b01, N + 6); check_out("t2_capture_op");
    enter_step(4'd3, 2'b10, N + 6); check_out("t2_done");

    // async reset mid-cycle
    #2 rst = 1'b1;
    #1;
    model_clear();
    push_exp();
    check_out("async_rst");
    @(negedge clk);
    rst = 1'b0;
    tick(12);
    push_exp();
    check_out("async_rst_release");

    // bounce shorter than debounce window is ignored
    sw = 4'd4;
    tick(3);
    btn_enter = 1'b1; tick(3);
    btn_enter = 1'b0; tick(1);
    btn_enter = 1'b1; tick(3);
    btn_enter = 1'b0; tick(12);
    push_exp();
    check_out("bounce_ignored");
    enter_step(4'd4, 2'b00, 10); check_out("steady_press");

    // switch changes alone do nothing
    sw = 4'hf; op_sel = 2'b10;
    tick(12);
    push_exp();
    check_out("switches_no_effect");
    clear_step(); check_out("clear_in_op");

    // unary op goes straight to DONE
    watch_sb = 1'b1;
    enter_step(4'd6, 2'b00, N + 6); check_out("t4_capture_a");
    enter_step(4'd6, 2'b11, N + 6); check_out("t4_twos_done");
    watch_sb = 1'b0;
    checks++;
    assert (seen_sb === 1'b0) passed++;
    else $error("FAIL t4_sb_skipped observed=%b expected=0", seen_sb);

    // enter while clear held down is ignored
    sw = 4'd2;
    btn_clear = 1'b1;
    tick(N + 6);
    model_clear();
    btn_enter = 1'b1;
    tick(N + 6);
    btn_enter = 1'b0;
    tick(N + 6);
    btn_clear = 1'b0;
    tick(N + 6);
    push_exp();
    check_out("enter_blocked_by_clear");

    // clear from S_B, then clear beats simultaneous enter
    enter_step(4'd2, 2'b00, N + 6); check_out("t5_capture_a");
    enter_step(4'd2, 2'b00, N + 6); check_out("t5_in_sb");
    clear_step(); check_out("t5_clear_in_sb");
    enter_step(4'd7, 2'b00, N + 6); check_out("t5_back_in_op");
    model_clear();
    push_exp();
    press(1'b1, 1'b1, N + 6);
    check_out("t5_clear_beats_enter");

    // new entry from DONE, then a long hold advances once
    enter_step(4'd1, 2'b10, N + 6); check_out("t6_capture_a");
    enter_step(4'd1, 2'b10, N + 6); check_out("t6_capture_op");
    enter_step(4'd8, 2'b10, N + 6); check_out("t6_done");
    enter_step(4'd9, 2'b10, N + 6); check_out("t6_restart_from_done");
    enter_step(4'd9, 2'b01, 50);    check_out("t6_long_hold_once");

    if (exp_q.size() != 0) begin
      checks++;
      $error("FAIL leftover_expected observed=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
